// File: rtl/iir_sos_cascade_if.sv
// Sample, scale, coefficient-write and result signals of iir_sos_cascade.
// Signal names follow the block's published pin names.
// master: the sample source / controller; drives X, X_VALID, S, C_WE, C_ADDR, C_DATA.
// slave : the cascade; drives X_READY, Y, Y_VALID, OF_add, OF_mult.
`timescale 1ns/1ps
interface iir_sos_cascade_if #(
    parameter int unsigned WIX  = 3,
    parameter int unsigned WFX  = 7,
    parameter int unsigned WIC  = 3,
    parameter int unsigned WFC  = 8,
    parameter int unsigned WIS  = 5,
    parameter int unsigned WFS  = 11,
    parameter int unsigned WIO  = 8,
    parameter int unsigned WFO  = 18,
    parameter int unsigned NSEC = 2,
    parameter int unsigned AW   = $clog2(5 * NSEC)
);
    logic signed [WIX+WFX-1:0] X;
    logic                      X_VALID;
    logic                      X_READY;
    logic signed [WIS+WFS-1:0] S;
    logic                      C_WE;
    logic        [AW-1:0]      C_ADDR;
    logic signed [WIC+WFC-1:0] C_DATA;
    logic signed [WIO+WFO-1:0] Y;
    logic                      Y_VALID;
    logic                      OF_add;
    logic                      OF_mult;

    modport master (
        output X, X_VALID, S, C_WE, C_ADDR, C_DATA,
        input  X_READY, Y, Y_VALID, OF_add, OF_mult
    );

    modport slave (
        input  X, X_VALID, S, C_WE, C_ADDR, C_DATA,
        output X_READY, Y, Y_VALID, OF_add, OF_mult
    );
endinterface

// File: rtl/iir_sos_cascade.sv
// Cascade of NSEC Direct Form I biquads sharing one multiply-accumulate unit.
// Each accepted sample is scaled by S, then every section takes 5 MAC cycles plus one
// update cycle; section k's output feeds section k+1. Coefficients are writable in IDLE.
// Ports:
//   CLK   - rising-edge clock
//   RESET - synchronous active-low reset
//   bus   - slave side of iir_sos_cascade_if (sample in, coefficient write, result out,
//           sticky overflow flags)
`timescale 1ns/1ps
module iir_sos_cascade #(
    parameter int unsigned WIX  = 3,
    parameter int unsigned WFX  = 7,
    parameter int unsigned WIC  = 3,
    parameter int unsigned WFC  = 8,
    parameter int unsigned WIS  = 5,
    parameter int unsigned WFS  = 11,
    parameter int unsigned WIO  = 8,
    parameter int unsigned WFO  = 18,
    parameter int unsigned NSEC = 2,
    parameter int unsigned AW   = $clog2(5 * NSEC)
) (
    input logic              CLK,
    input logic              RESET,
    iir_sos_cascade_if.slave bus
);

    localparam int unsigned XW  = WIX + WFX;
    localparam int unsigned CW  = WIC + WFC;
    localparam int unsigned SW  = WIS + WFS;
    localparam int unsigned OW  = WIO + WFO;
    localparam int unsigned PW  = XW + SW;
    localparam int unsigned PF  = WFX + WFS;
    localparam int unsigned ShR = (PF > WFO) ? PF - WFO : 0;
    localparam int unsigned ShL = (PF < WFO) ? WFO - PF : 0;
    // Room for the aligned product plus headroom for the range check.
    localparam int unsigned EW  = PW + ShL + OW;
    localparam int unsigned MW  = CW + OW;
    localparam int unsigned ACW = (WIC + WIO + 3) + (WFC + WFO);
    localparam int unsigned NC  = 5 * NSEC;
    localparam int unsigned KW  = (NSEC > 1) ? $clog2(NSEC) : 1;

    localparam logic signed [OW-1:0]  OutMax  = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0]  OutMin  = {1'b1, {(OW-1){1'b0}}};
    localparam logic signed [EW-1:0]  ScMax   = EW'(OutMax);
    localparam logic signed [EW-1:0]  ScMin   = EW'(OutMin);
    localparam logic signed [ACW-1:0] AccMax  = ACW'(OutMax);
    localparam logic signed [ACW-1:0] AccMin  = ACW'(OutMin);
    localparam logic signed [CW-1:0]  B0Reset = CW'(1 << WFC);

    typedef enum logic [1:0] {StIdle, StScale, StMac, StUpd} state_e;

    state_e                state_q;
    logic [KW-1:0]         k_q;
    logic [2:0]            j_q;
    logic signed [XW-1:0]  x_q;
    logic signed [SW-1:0]  s_q;
    logic signed [OW-1:0]  xin_q;   // input of the section being computed
    logic signed [ACW-1:0] acc_q;
    logic signed [OW-1:0]  y_q;
    logic                  y_valid_q;
    logic                  of_add_q;
    logic                  of_mult_q;
    logic signed [CW-1:0]  coef_q [NC];
    logic signed [OW-1:0]  x1_q [NSEC];
    logic signed [OW-1:0]  x2_q [NSEC];
    logic signed [OW-1:0]  y1_q [NSEC];
    logic signed [OW-1:0]  y2_q [NSEC];

    // Input scaling: X*S aligned to WIO.WFO with floor / zero-pad, then saturated.
    logic signed [PW-1:0] sc_prod;
    logic signed [EW-1:0] sc_al;
    logic signed [OW-1:0] sc_sat;
    logic                 sc_of;

    always_comb begin
        sc_prod = PW'(x_q) * PW'(s_q);
        sc_al   = (EW'(sc_prod) >>> ShR) <<< ShL;
        sc_of   = 1'b0;
        sc_sat  = sc_al[OW-1:0];
        if (sc_al > ScMax) begin
            sc_sat = OutMax;
            sc_of  = 1'b1;
        end else if (sc_al < ScMin) begin
            sc_sat = OutMin;
            sc_of  = 1'b1;
        end
    end

    // MAC: j selects b0*x, b1*x1, b2*x2, then subtracts a1*y1, a2*y2.
    logic [AW-1:0]         cidx;
    logic signed [CW-1:0]  mac_coef;
    logic signed [OW-1:0]  mac_op;
    logic signed [MW-1:0]  mac_prod;
    logic signed [ACW-1:0] mac_term;
    logic signed [ACW-1:0] acc_base;
    logic signed [ACW-1:0] acc_sum;

    always_comb begin
        cidx     = AW'(32'd5 * 32'(k_q) + 32'(j_q));
        mac_coef = coef_q[cidx];
        case (j_q)
            3'd0:    mac_op = xin_q;
            3'd1:    mac_op = x1_q[k_q];
            3'd2:    mac_op = x2_q[k_q];
            3'd3:    mac_op = y1_q[k_q];
            3'd4:    mac_op = y2_q[k_q];
            default: mac_op = '0;
        endcase
        mac_prod = MW'(mac_coef) * MW'(mac_op);
        mac_term = ACW'(mac_prod);
        acc_base = (j_q == 3'd0) ? '0 : acc_q;
        acc_sum  = (j_q >= 3'd3) ? acc_base - mac_term : acc_base + mac_term;
    end

    // Section output: floor away the coefficient fraction, then saturate.
    logic signed [ACW-1:0] acc_sh;
    logic signed [OW-1:0]  y_upd;
    logic                  upd_of;

    always_comb begin
        acc_sh = acc_q >>> WFC;
        upd_of = 1'b0;
        y_upd  = acc_sh[OW-1:0];
        if (acc_sh > AccMax) begin
            y_upd  = OutMax;
            upd_of = 1'b1;
        end else if (acc_sh < AccMin) begin
            y_upd  = OutMin;
            upd_of = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= StIdle;
            k_q       <= '0;
            j_q       <= '0;
            x_q       <= '0;
            s_q       <= '0;
            xin_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            of_add_q  <= 1'b0;
            of_mult_q <= 1'b0;
            for (int i = 0; i < int'(NSEC); i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
            for (int i = 0; i < int'(NC); i++) begin
                coef_q[i] <= ((i % 5) == 0) ? B0Reset : '0;
            end
        end else begin
            y_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.C_WE && (32'(bus.C_ADDR) < NC)) begin
                        coef_q[bus.C_ADDR] <= bus.C_DATA;
                    end
                    if (bus.X_VALID) begin
                        x_q     <= bus.X;
                        s_q     <= bus.S;
                        state_q <= StScale;
                    end
                end
                StScale: begin
                    xin_q     <= sc_sat;
                    of_mult_q <= of_mult_q | sc_of;
                    k_q       <= '0;
                    j_q       <= '0;
                    state_q   <= StMac;
                end
                StMac: begin
                    acc_q <= acc_sum;
                    if (j_q == 3'd4) begin
                        state_q <= StUpd;
                    end else begin
                        j_q <= j_q + 3'd1;
                    end
                end
                StUpd: begin
                    x2_q[k_q] <= x1_q[k_q];
                    x1_q[k_q] <= xin_q;
                    y2_q[k_q] <= y1_q[k_q];
                    y1_q[k_q] <= y_upd;
                    xin_q     <= y_upd;
                    of_add_q  <= of_add_q | upd_of;
                    j_q       <= '0;
                    if (32'(k_q) == NSEC - 1) begin
                        y_q       <= y_upd;
                        y_valid_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        state_q <= StMac;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.X_READY = (state_q == StIdle);
    assign bus.Y       = y_q;
    assign bus.Y_VALID = y_valid_q;
    assign bus.OF_add  = of_add_q;
    assign bus.OF_mult = of_mult_q;

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Directed bench for iir_sos_cascade with default parameters (NSEC = 2).
// Formats: X 3.7, S 5.11, coefficients 3.8, Y 8.18.
`timescale 1ns/1ps
module tb_iir_sos_cascade;

    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_bad = 0;

    iir_sos_cascade_if bus ();

    iir_sos_cascade dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [9:0]  b2b_x [6];
    logic [25:0] b2b_y [6];

    initial begin
        b2b_x = '{10'h040, 10'h3C0, 10'h001, 10'h1FF, 10'h200, 10'h07F};
        b2b_y = '{26'h0020000, 26'h3FE0000, 26'h0000800, 26'h00FF800, 26'h3F00000,
                  26'h003F800};
    end

    task automatic apply_reset();
        @(negedge CLK);
        bus.X_VALID = 1'b0;
        bus.C_WE    = 1'b0;
        RESET       = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [10:0] data);
        @(negedge CLK);
        bus.C_WE   = 1'b1;
        bus.C_ADDR = addr;
        bus.C_DATA = data;
        @(negedge CLK);
        bus.C_WE = 1'b0;
    endtask

    // Presents one sample in IDLE; returns Y and the number of cycles to Y_VALID
    // (-1 and Y = x on timeout).
    task automatic run_sample(input logic [9:0] x, input logic [15:0] s,
                              output logic [25:0] y, output int lat);
        @(negedge CLK);
        bus.X       = x;
        bus.S       = s;
        bus.X_VALID = 1'b1;
        @(negedge CLK);
        bus.X_VALID = 1'b0;
        lat = -1;
        y   = 'x;
        for (int n = 1; n <= 40; n++) begin
            if (bus.Y_VALID) begin
                lat = n;
                y   = bus.Y;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RESET       = 1'b0;
        bus.X_VALID = 1'b0;
        bus.X       = '0;
        bus.S       = '0;
        bus.C_WE    = 1'b0;
        bus.C_ADDR  = '0;
        bus.C_DATA  = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (bus.X_READY !== 1'b1) begin
            n_bad++; $display("FAIL reset_x_ready: got %b want 1", bus.X_READY);
        end
        n_cmp++;
        if (bus.Y !== 26'h0) begin
            n_bad++; $display("FAIL reset_y: got %h want 0", bus.Y);
        end
        n_cmp++;
        if (bus.Y_VALID !== 1'b0) begin
            n_bad++; $display("FAIL reset_y_valid: got %b want 0", bus.Y_VALID);
        end
        n_cmp++;
        if (bus.OF_add !== 1'b0 || bus.OF_mult !== 1'b0) begin
            n_bad++; $display("FAIL reset_of: got add=%b mult=%b want 0 0", bus.OF_add, bus.OF_mult);
        end
    endtask

    task automatic test_pass_through();
        logic [25:0] y;
        int          lat;
        run_sample(10'h040, 16'h0800, y, lat);
        n_cmp++;
        if (lat !== 14) begin
            n_bad++; $display("FAIL pass_latency: got %0d want 14", lat);
        end
        n_cmp++;
        if (y !== 26'h0020000) begin
            n_bad++; $display("FAIL pass_y: got %h want 0020000", y);
        end
        n_cmp++;
        if (bus.OF_add !== 1'b0 || bus.OF_mult !== 1'b0) begin
            n_bad++; $display("FAIL pass_of: got add=%b mult=%b want 0 0", bus.OF_add, bus.OF_mult);
        end
        @(negedge CLK);
        n_cmp++;
        if (bus.Y_VALID !== 1'b0 || bus.Y !== 26'h0020000) begin
            n_bad++; $display("FAIL pass_strobe: got v=%b y=%h want v=0 y=0020000",
                              bus.Y_VALID, bus.Y);
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] got [6];
        int          t [6];
        int          idx = 0;
        int          npulse = 0;
        int          nlow = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            got[i] = 'x;
            t[i]   = -100;
        end
        bus.S = 16'h0800;
        @(negedge CLK);
        for (int c = 0; c < 110; c++) begin
            if (!bus.X_READY) nlow++;
            if (bus.Y_VALID) begin
                if (npulse < 6) begin
                    got[npulse] = bus.Y;
                    t[npulse]   = c;
                end
                npulse++;
            end
            if (bus.X_READY) begin
                if (idx < 6) begin
                    bus.X       = b2b_x[idx];
                    bus.X_VALID = 1'b1;
                    idx++;
                end else begin
                    bus.X_VALID = 1'b0;
                end
            end
            @(negedge CLK);
        end
        n_cmp++;
        if (npulse !== 6) begin
            n_bad++; $display("FAIL b2b_pulses: got %0d want 6", npulse);
        end
        n_cmp++;
        if (nlow !== 78) begin
            n_bad++; $display("FAIL b2b_ready_low: got %0d want 78", nlow);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[i] !== b2b_y[i]) begin
                n_bad++; $display("FAIL b2b_y[%0d]: got %h want %h", i, got[i], b2b_y[i]);
            end
        end
        for (int i = 1; i < 6; i++) begin
            n_cmp++;
            if (t[i] - t[i-1] !== 14) begin
                n_bad++; $display("FAIL b2b_period[%0d]: got %0d want 14", i, t[i] - t[i-1]);
            end
        end
    endtask

    task automatic test_impulse();
        logic [25:0] exp_y [5];
        logic [25:0] y;
        int          lat;
        exp_y = '{26'h0040000, 26'h0020000, 26'h0010000, 26'h0008000, 26'h0004000};
        apply_reset();
        write_coef(4'd3, 11'h780);  // section 0 a1 = -0.5
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 10'h080 : 10'h000, 16'h0800, y, lat);
            n_cmp++;
            if (y !== exp_y[i]) begin
                n_bad++; $display("FAIL impulse_y[%0d]: got %h want %h", i, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_ignored_writes();
        logic [25:0] y;
        int          lat;
        logic        seen;
        apply_reset();
        @(negedge CLK);
        bus.X       = 10'h080;
        bus.S       = 16'h0800;
        bus.X_VALID = 1'b1;
        @(negedge CLK);
        bus.X_VALID = 1'b0;
        @(negedge CLK);
        bus.C_WE   = 1'b1;  // held through MAC cycles of section 0
        bus.C_ADDR = 4'd0;
        bus.C_DATA = 11'h300;
        repeat (4) @(negedge CLK);
        bus.C_WE = 1'b0;
        seen = 1'b0;
        y    = 'x;
        for (int n = 0; n < 30 && !seen; n++) begin
            if (bus.Y_VALID) begin
                seen = 1'b1;
                y    = bus.Y;
            end else begin
                @(negedge CLK);
            end
        end
        n_cmp++;
        if (y !== 26'h0040000) begin
            n_bad++; $display("FAIL ign_busy_y: got %h want 0040000", y);
        end
        write_coef(4'd10, 11'h300);  // beyond the last coefficient
        run_sample(10'h080, 16'h0800, y, lat);
        n_cmp++;
        if (y !== 26'h0040000) begin
            n_bad++; $display("FAIL ign_impulse0: got %h want 0040000", y);
        end
        run_sample(10'h000, 16'h0800, y, lat);
        n_cmp++;
        if (y !== 26'h0000000) begin
            n_bad++; $display("FAIL ign_impulse1: got %h want 0000000", y);
        end
    endtask

    task automatic test_saturation();
        logic [25:0] y;
        int          lat;
        apply_reset();
        write_coef(4'd0, 11'h300);
        write_coef(4'd5, 11'h300);
        run_sample(10'h180, 16'h7800, y, lat);  // 3.0 * 15.0 = 45, *3 *3 overflows
        n_cmp++;
        if (y !== 26'h1FFFFFF) begin
            n_bad++; $display("FAIL sat_y: got %h want 1FFFFFF", y);
        end
        n_cmp++;
        if (bus.OF_add !== 1'b1 || bus.OF_mult !== 1'b0) begin
            n_bad++; $display("FAIL sat_flags: got add=%b mult=%b want 1 0", bus.OF_add, bus.OF_mult);
        end
        run_sample(10'h040, 16'h0800, y, lat);  // 0.5 * 9 = 4.5
        n_cmp++;
        if (y !== 26'h0120000) begin
            n_bad++; $display("FAIL sat_after_y: got %h want 0120000", y);
        end
        n_cmp++;
        if (bus.OF_add !== 1'b1) begin
            n_bad++; $display("FAIL sat_sticky: got %b want 1", bus.OF_add);
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] y;
        int          lat;
        int          nv = 0;
        @(negedge CLK);
        bus.X       = 10'h0C0;
        bus.S       = 16'h0800;
        bus.X_VALID = 1'b1;
        @(negedge CLK);        // accept edge E0 has passed
        bus.X_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b0;          // sampled at E0+5
        @(negedge CLK);
        RESET = 1'b1;
        n_cmp++;
        if (bus.X_READY !== 1'b1 || bus.OF_add !== 1'b0) begin
            n_bad++; $display("FAIL mid_state: got ready=%b add=%b want 1 0", bus.X_READY, bus.OF_add);
        end
        for (int c = 0; c < 20; c++) begin
            if (bus.Y_VALID) nv++;
            @(negedge CLK);
        end
        n_cmp++;
        if (nv !== 0 || bus.Y !== 26'h0) begin
            n_bad++; $display("FAIL mid_no_result: got pulses=%0d y=%h want 0 0", nv, bus.Y);
        end
        write_coef(4'd3, 11'h780);
        run_sample(10'h080, 16'h0800, y, lat);
        n_cmp++;
        if (y !== 26'h0040000) begin
            n_bad++; $display("FAIL mid_impulse0: got %h want 0040000", y);
        end
        run_sample(10'h000, 16'h0800, y, lat);
        n_cmp++;
        if (y !== 26'h0020000) begin
            n_bad++; $display("FAIL mid_impulse1: got %h want 0020000", y);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_back_to_back();
        test_impulse();
        test_ignored_writes();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
